// File: rtl/operand_fetch_sequencer.sv
// Resolves up to four instruction arguments (immediate or register read) into extended 64-bit operands.
// Latency 2+m+2k+g cycles from accept; rf_req is held until rf_gnt, and the bundle is held until out_ready.
module operand_fetch_sequencer #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [295:0]          in_instr,
  input  logic [2:0]            in_num_args,
  output logic                  rf_req,
  output logic [REG_ADDR_W-1:0] rf_addr,
  input  logic                  rf_gnt,
  input  logic [63:0]           rf_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_opcode,
  output logic [7:0]            out_flags,
  output logic [63:0]           out_op0,
  output logic [63:0]           out_op1,
  output logic [63:0]           out_op2,
  output logic [63:0]           out_op3
);

  typedef struct packed {
    logic [15:0] opcode;
    logic [3:0]  arg_size0;
    logic [3:0]  arg_size1;
    logic [3:0]  arg_size2;
    logic [3:0]  arg_size3;
    logic [7:0]  flags;
    logic [63:0] arg0;
    logic [63:0] arg1;
    logic [63:0] arg2;
    logic [63:0] arg3;
  } instruction_t;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, OUT} state_t;

  state_t            state_q, state_d;
  instruction_t      instr_q;
  logic [2:0]        num_q;
  logic [2:0]        idx_q;
  logic [3:0][63:0]  op_q;

  logic [63:0] cur_arg;
  logic [3:0]  cur_size;
  logic        cur_sgn;
  logic        cur_imm;
  logic        accept;
  logic        ld_imm;
  logic        ld_rd;

  function automatic logic [63:0] ext(input logic [63:0] v, input logic [3:0] sz, input logic sgn);
    logic [63:0] r;
    case (sz)
      4'd0:    r = {{56{sgn & v[7]}},  v[7:0]};
      4'd1:    r = {{48{sgn & v[15]}}, v[15:0]};
      4'd2:    r = {{32{sgn & v[31]}}, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    cur_arg  = '0;
    cur_size = '0;
    case (idx_q[1:0])
      2'd0: begin cur_arg = instr_q.arg0; cur_size = instr_q.arg_size0; end
      2'd1: begin cur_arg = instr_q.arg1; cur_size = instr_q.arg_size1; end
      2'd2: begin cur_arg = instr_q.arg2; cur_size = instr_q.arg_size2; end
      default: begin cur_arg = instr_q.arg3; cur_size = instr_q.arg_size3; end
    endcase
    cur_imm = instr_q.flags[{1'b0, idx_q[1:0]}];
    cur_sgn = instr_q.flags[{1'b1, idx_q[1:0]}];
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    rf_req    = 1'b0;
    rf_addr   = '0;
    out_valid = 1'b0;
    accept    = 1'b0;
    ld_imm    = 1'b0;
    ld_rd     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          accept  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (idx_q >= num_q) begin
          state_d = OUT;
        end else if (cur_imm) begin
          ld_imm = 1'b1;
        end else begin
          rf_req  = 1'b1;
          rf_addr = cur_arg[REG_ADDR_W-1:0];
          if (rf_gnt) state_d = WAIT;
        end
      end
      WAIT: begin
        ld_rd   = 1'b1;
        state_d = FETCH;
      end
      default: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
    endcase
    // Abort suppresses any operand write so a late read return is dropped.
    if (flush) begin
      state_d = IDLE;
      ld_imm  = 1'b0;
      ld_rd   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      op_q    <= '0;
    end else if (accept) begin
      instr_q <= instruction_t'(in_instr);
      num_q   <= (in_num_args > 3'd4) ? 3'd4 : in_num_args;
      idx_q   <= '0;
      op_q    <= '0;
    end else if (ld_imm || ld_rd) begin
      op_q[idx_q[1:0]] <= ext(ld_imm ? cur_arg : rf_rdata, cur_size, cur_sgn);
      idx_q            <= idx_q + 3'd1;
    end
  end

  assign out_opcode = instr_q.opcode;
  assign out_flags  = instr_q.flags;
  assign out_op0    = op_q[0];
  assign out_op1    = op_q[1];
  assign out_op2    = op_q[2];
  assign out_op3    = op_q[3];

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Scoreboard bench for operand_fetch_sequencer: stimulus pushes expected bundles, a monitor pops them on handshake.
module tb_operand_fetch_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [295:0] in_instr;
  logic [2:0]   in_num_args;
  logic         rf_req;
  logic [4:0]   rf_addr;
  logic         rf_gnt;
  logic [63:0]  rf_rdata;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_opcode;
  logic [7:0]   out_flags;
  logic [63:0]  out_op0, out_op1, out_op2, out_op3;

  operand_fetch_sequencer #(.REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_num_args(in_num_args),
    .rf_req(rf_req), .rf_addr(rf_addr), .rf_gnt(rf_gnt), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_flags(out_flags),
    .out_op0(out_op0), .out_op1(out_op1), .out_op2(out_op2), .out_op3(out_op3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]      opc;
    logic [7:0]       fl;
    logic [3:0][63:0] op;
    int               exp_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [4:0]  addr_q[$];
  logic [63:0] rf_model [32];
  int          cmp_cnt = 0;
  int          err_cnt = 0;
  int          cyc = 0;
  int          stall_cfg = 0;
  int          req_cycles = 0;

  always @(posedge clk) cyc++;

  // Independent extension model: shift the field to the top, then shift back arithmetically or logically.
  function automatic logic [63:0] tb_ext(input logic [63:0] v, input logic [3:0] sz, input logic s);
    int w;
    logic [63:0] t;
    w = (sz == 4'd0) ? 8 : (sz == 4'd1) ? 16 : (sz == 4'd2) ? 32 : 64;
    if (w == 64) return v;
    t = v << (64 - w);
    if (s) return $signed(t) >>> (64 - w);
    return t >> (64 - w);
  endfunction

  // Register-file responder: optional grant stall, read data the cycle after grant, junk otherwise.
  initial begin : responder
    int   stall_cnt;
    bit   gnt_prev;
    logic [4:0] addr_prev, held, ea;
    stall_cnt = 0; gnt_prev = 0; addr_prev = '0; held = '0;
    rf_gnt = 1'b0; rf_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        rf_gnt = 1'b0; stall_cnt = 0; gnt_prev = 0;
        continue;
      end
      rf_rdata = gnt_prev ? rf_model[addr_prev] : {$urandom, $urandom};
      gnt_prev = 0;
      rf_gnt   = 1'b0;
      if (rf_req) begin
        req_cycles++;
        if (stall_cnt > 0) begin
          cmp_cnt++;
          if (rf_addr !== held) begin
            err_cnt++;
            $display("FAIL rf_addr_hold: got %0d need %0d", rf_addr, held);
          end
        end
        if (stall_cnt < stall_cfg) begin
          if (stall_cnt == 0) held = rf_addr;
          stall_cnt++;
        end else begin
          rf_gnt = 1'b1; gnt_prev = 1; addr_prev = rf_addr; stall_cnt = 0;
          cmp_cnt++;
          if (addr_q.size() == 0) begin
            err_cnt++;
            $display("FAIL rf_addr_unexpected: got %0d need no request", rf_addr);
          end else begin
            ea = addr_q.pop_front();
            if (rf_addr !== ea) begin
              err_cnt++;
              $display("FAIL rf_addr: got %0d need %0d", rf_addr, ea);
            end
          end
        end
      end else begin
        stall_cnt = 0;
        rf_gnt = 1'($urandom_range(0, 1));
      end
    end
  end

  // Output monitor: latency on first valid cycle, stability under backpressure, contents on handshake.
  initial begin : monitor
    bit   prev_valid, prev_stall;
    logic [271:0] snap, cur;
    exp_t e;
    prev_valid = 0; prev_stall = 0; snap = '0;
    forever begin
      @(negedge clk);
      cur = {out_opcode, out_flags, out_op3, out_op2, out_op1, out_op0};
      if (!rst_n || !out_valid) begin
        prev_valid = 0; prev_stall = 0;
        continue;
      end
      if (!prev_valid) begin
        cmp_cnt++;
        if (sb.size() == 0) begin
          err_cnt++;
          $display("FAIL unexpected_out_valid: got valid at cycle %0d need none", cyc);
        end else if (cyc != sb[0].exp_cyc) begin
          err_cnt++;
          $display("FAIL latency: got cycle %0d need %0d", cyc, sb[0].exp_cyc);
        end
      end else if (prev_stall) begin
        cmp_cnt++;
        if (cur !== snap) begin
          err_cnt++;
          $display("FAIL hold_stable: got %h need %h", cur, snap);
        end
      end
      if (out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        cmp_cnt++;
        if (out_opcode !== e.opc || out_flags !== e.fl) begin
          err_cnt++;
          $display("FAIL opcode_flags: got %h/%h need %h/%h", out_opcode, out_flags, e.opc, e.fl);
        end
        cmp_cnt++;
        if ({out_op3, out_op2, out_op1, out_op0} !== e.op) begin
          err_cnt++;
          $display("FAIL operands: got %h %h %h %h need %h %h %h %h",
                   out_op0, out_op1, out_op2, out_op3, e.op[0], e.op[1], e.op[2], e.op[3]);
        end
      end
      prev_valid = 1;
      prev_stall = !out_ready;
      snap = cur;
    end
  end

  // Called at posedge+1; the instruction is accepted at the following edge.
  task automatic send(input logic [15:0] opc, input logic [15:0] sz, input logic [7:0] fl,
                      input logic [63:0] a0, input logic [63:0] a1, input logic [63:0] a2,
                      input logic [63:0] a3, input logic [2:0] n, input int lat, input bit push);
    exp_t e;
    logic [63:0] a [4];
    logic [3:0] s;
    int nn;
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    nn = (n > 3'd4) ? 4 : int'(n);
    e.opc = opc; e.fl = fl; e.op = '0;
    for (int i = 0; i < nn; i++) begin
      s = sz[4*i +: 4];
      if (fl[i]) begin
        e.op[i] = tb_ext(a[i], s, fl[4+i]);
      end else begin
        e.op[i] = tb_ext(rf_model[a[i][4:0]], s, fl[4+i]);
        addr_q.push_back(a[i][4:0]);
      end
    end
    in_instr    = {opc, sz[3:0], sz[7:4], sz[11:8], sz[15:12], fl, a0, a1, a2, a3};
    in_num_args = n;
    in_valid    = 1'b1;
    e.exp_cyc   = cyc + lat;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0 && in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    cmp_cnt++;
    if ({in_ready, rf_req, rf_addr, out_valid} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got rdy=%b req=%b addr=%0d vld=%b need 1 0 0 0", in_ready, rf_req, rf_addr, out_valid);
    end
    cmp_cnt++;
    if ({out_opcode, out_flags, out_op0, out_op1, out_op2, out_op3} !== 280'd0) begin
      err_cnt++;
      $display("FAIL reset_data: got %h %h %h need all zero", out_opcode, out_flags, out_op0);
    end
  endtask

  task automatic test_all_immediate;
    bit ok; int r0;
    r0 = req_cycles;
    send(16'h00A1, 16'h0003, 8'h03, 64'h1234, 64'hFF, 64'hDEAD, 64'hBEEF, 3'd2, 4, 1);
    wait_done(ok);
    cmp_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL imm_timeout: got busy need done"); end
    cmp_cnt++;
    if (req_cycles != r0) begin err_cnt++; $display("FAIL imm_no_rf_req: got %0d req cycles need 0", req_cycles - r0); end
  endtask

  task automatic test_register_sign;
    bit ok;
    rf_model[7] = 64'h0000_0000_0000_8001;
    send(16'h00B2, 16'h0001, 8'h10, 64'hFFE7, 64'h0, 64'h0, 64'h0, 3'd1, 4, 1);
    wait_done(ok);
    cmp_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL regsign_timeout: got busy need done"); end
  endtask

  task automatic test_grant_stall;
    bit ok; int r0;
    rf_model[12] = 64'h0000_0001_7FFF_FFFF;
    stall_cfg = 3;
    r0 = req_cycles;
    send(16'h00C3, 16'h0002, 8'h10, 64'd12, 64'h0, 64'h0, 64'h0, 3'd1, 7, 1);
    wait_done(ok);
    stall_cfg = 0;
    cmp_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL stall_timeout: got busy need done"); end
    cmp_cnt++;
    if (req_cycles - r0 != 4) begin err_cnt++; $display("FAIL stall_req_cycles: got %0d need 4", req_cycles - r0); end
  endtask

  task automatic test_mixed_four;
    bit ok;
    rf_model[3] = 64'h1122_3344_5566_7788;
    rf_model[4] = 64'hDEAD_BEEF_8000_0001;
    send(16'h00D4, 16'h2330, 8'h15, 64'h80, 64'd3, 64'd5, 64'd4, 3'd4, 8, 1);
    wait_done(ok);
    cmp_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL mixed_timeout: got busy need done"); end
  endtask

  task automatic test_num_args_bounds;
    bit ok; int r0;
    r0 = req_cycles;
    send(16'h00E5, 16'h0000, 8'h00, 64'd1, 64'd2, 64'd3, 64'd4, 3'd0, 2, 1);
    wait_done(ok);
    cmp_cnt++;
    if (!ok || req_cycles != r0) begin
      err_cnt++; $display("FAIL zero_args: got ok=%0d req=%0d need ok=1 req=0", ok, req_cycles - r0);
    end
    send(16'h00E6, 16'hF210, 8'hFF, 64'h7F, 64'h1_8000, 64'hFFFF_FFFF_0000_0000,
         64'h8000_0000_0000_0001, 3'd7, 6, 1);
    wait_done(ok);
    cmp_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL clamp_timeout: got busy need done"); end
  endtask

  task automatic test_backpressure_flush;
    bit ok, seen;
    logic [271:0] snap;
    out_ready = 1'b0;
    send(16'h00F7, 16'h0000, 8'h11, 64'h90, 64'h0, 64'h0, 64'h0, 3'd1, 3, 1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (out_valid) seen = 1; else begin @(posedge clk); #1; end
    end
    snap = {out_opcode, out_flags, out_op3, out_op2, out_op1, out_op0};
    repeat (5) begin @(posedge clk); #1; end
    cmp_cnt++;
    if (!seen || !out_valid || {out_opcode, out_flags, out_op3, out_op2, out_op1, out_op0} !== snap) begin
      err_cnt++; $display("FAIL backpressure_hold: got vld=%b seen=%0d need held bundle", out_valid, seen);
    end
    out_ready = 1'b1;
    wait_done(ok);
    // Flush while waiting for the read data.
    rf_model[9]  = 64'hAAAA_5555_AAAA_5555;
    rf_model[10] = 64'h0000_0000_0000_0042;
    send(16'h0108, 16'h0003, 8'h00, 64'd9, 64'h0, 64'h0, 64'h0, 3'd1, 0, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rf_req && rf_gnt) seen = 1;
    end
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    cmp_cnt++;
    if (!seen || {in_ready, rf_req, out_valid} !== 3'b100 || out_op0 !== 64'd0) begin
      err_cnt++;
      $display("FAIL flush_wait: got seen=%0d rdy=%b req=%b vld=%b op0=%h need 1 1 0 0 0",
               seen, in_ready, rf_req, out_valid, out_op0);
    end
    send(16'h0109, 16'h0003, 8'h00, 64'd10, 64'h0, 64'h0, 64'h0, 3'd1, 4, 1);
    wait_done(ok);
    cmp_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL after_flush_timeout: got busy need done"); end
    // Flush beats in_valid in IDLE: nothing is accepted.
    in_instr = '0; in_num_args = 3'd0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    cmp_cnt++;
    if (!in_ready || out_valid) begin
      err_cnt++; $display("FAIL flush_idle: got rdy=%b vld=%b need 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_async_reset;
    bit ok, seen;
    stall_cfg = 20;
    rf_model[15] = 64'h1;
    send(16'h010A, 16'h0003, 8'h00, 64'd15, 64'h0, 64'h0, 64'h0, 3'd1, 0, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rf_req) seen = 1;
    end
    #2 rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if (!seen || {rf_req, in_ready, out_valid} !== 3'b010 || out_opcode !== 16'd0) begin
      err_cnt++;
      $display("FAIL async_reset: got seen=%0d req=%b rdy=%b vld=%b opc=%h need 1 0 1 0 0",
               seen, rf_req, in_ready, out_valid, out_opcode);
    end
    @(posedge clk); #1;
    addr_q.delete();
    stall_cfg = 0;
    rst_n = 1'b1;
    rf_model[16] = 64'hFFFF_FFFF_FFFF_FF01;
    send(16'h010B, 16'h0000, 8'h10, 64'd16, 64'h0, 64'h0, 64'h0, 3'd1, 4, 1);
    wait_done(ok);
    cmp_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL post_reset_timeout: got busy need done"); end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish need finish");
    err_cnt++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = {$urandom, $urandom};
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_num_args = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_all_immediate();
    test_register_sign();
    test_grant_stall();
    test_mixed_four();
    test_num_args_bounds();
    test_backpressure_flush();
    test_async_reset();
    repeat (3) @(posedge clk);
    cmp_cnt++;
    if (sb.size() != 0 || addr_q.size() != 0) begin
      err_cnt++; $display("FAIL leftover: got sb=%0d addr=%0d need 0 0", sb.size(), addr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/operand_fetch_sequencer.md
Name: operand_fetch_sequencer

Overview:
- Sits between decode and execute.
- Accepts one decoded instruction_t and, in argument order, resolves each used argument to a 64-bit operand.
  - Immediates (flags bit n = USE_ARGn_AS_IMMIDIATE) are taken from the instruction word.
  - Register arguments are read over a shared, granted register-file read port.
- Each operand is zero/sign-extended per its argSize and ARGn_SIGN_EXTEND flag, then the bundle is presented to execute with valid/ready.

Parameters:
- REG_ADDR_W, 5, register index width; register number is argN[REG_ADDR_W-1:0].

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of the current instruction.
- in_valid  in  1  decoded instruction available.
- in_ready  out  1  sequencer can accept.
- in_instr  in  296  packed instruction_t {opcode16, argSize0..3 4 each, flags8, arg0..3 64 each}.
- in_num_args  in  3  arguments used by the opcode; values >4 treated as 4.
- rf_req  out  1  register read request.
- rf_addr  out  REG_ADDR_W  register index.
- rf_gnt  in  1  request accepted this cycle.
- rf_rdata  in  64  read data, valid the cycle after rf_gnt.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  execute accepts.
- out_opcode  out  16  latched opcode.
- out_flags  out  8  latched flags.
- out_op0..out_op3  out  64 each  extended operands.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, rf_req=0, rf_addr=0, out_valid=0, out_opcode=0, out_flags=0, all out_op*=0, idx=0.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid: latch instr and clamped num_args, clear all operand registers to 0, idx=0, go to FETCH.
  - FETCH (evaluates arg[idx]):
    - idx>=num_args: go to OUT.
    - Immediate: store ext(arg[idx]) in op[idx], idx++, stay in FETCH. Costs 1 cycle.
    - Register: rf_req=1, rf_addr=arg[idx][REG_ADDR_W-1:0].
      - If rf_gnt, go to WAIT.
      - Otherwise hold rf_req/rf_addr stable until rf_gnt.
  - WAIT: capture ext(rf_rdata) into op[idx], idx++, rf_req=0, go to FETCH.
  - OUT:
    - out_valid=1; outputs held stable until out_ready.
    - On out_valid&&out_ready, go to IDLE.
- in_ready is 1 only in IDLE; no overlap between instructions.
- Latency: accept at cycle T gives out_valid at T+2+m+2k+g.
  - m = immediates, k = register args, g = total grant-stall cycles.
  - num_args=0 gives out_valid at T+2.
- Operands with index >= num_args are 0.
- Extension (applies to immediates and register data alike):
  - argSize 0 → 8 bits, 1 → 16, 2 → 32, 3 and 4..15 → 64 (no change).
  - If flags[4+n] (ARGn_SIGN_EXTEND) is set, replicate the top bit of the selected width; otherwise zero-fill.
- flush:
  - Any state goes to IDLE next cycle; rf_req and out_valid drop.
  - rf_rdata arriving after a flushed WAIT is ignored.
  - flush takes priority over in_valid in IDLE: nothing is accepted that cycle.
- rf_gnt outside FETCH-with-rf_req is ignored.
- Reset mid-operation: immediate return to reset values; no partial bundle is ever emitted.

Test Plan:
1. All-immediate:
   - Stimulus: num_args=2, flags=0x03, arg0=0x1234, arg1=0xFF, sizes 64/8, flags[5]=0.
   - Required: out_op0=0x1234, out_op1=0xFF, out_valid at T+4, rf_req never asserted.
2. Register with sign-extend:
   - Stimulus: num_args=1, flags=0x10, arg0=7, argSize0=BITS_16, rf_gnt immediate, rf_rdata=0x0000_0000_0000_8001.
   - Required: rf_addr=7, out_op0=0xFFFF_FFFF_FFFF_8001, out_valid at T+4.
3. Grant stall:
   - Stimulus: register arg with rf_gnt low 3 cycles.
   - Required: rf_req/rf_addr held stable for 4 cycles; out_valid at T+7.
4. Mixed four args:
   - Stimulus: flags=0x05, arg0 imm 0x80 BITS_8 sign-extended (flags|=0x10), arg1 reg 3, arg2 imm 5, arg3 reg 4.
   - Required: out_op0=0xFFFF_FFFF_FFFF_FF80, out_op1 and out_op3 from the reads in order, out_valid at T+8.
5. Backpressure then flush:
   - Stimulus: out_ready=0 for 5 cycles.
   - Required: outputs stable throughout.
   - Then: flush during the WAIT of the next instruction gives IDLE next cycle, no out_valid, and the late rf_rdata is ignored.
6. Async reset:
   - Stimulus: rst_n low mid-FETCH with rf_req=1.
   - Required: rf_req=0 and in_ready=1 immediately, with no clock edge needed.
